// File: rtl/lotr_pkg.sv
// Shared types for the ring endpoint: opcodes, ring slot payload, initiator FSM states.
package lotr_pkg;

    typedef enum logic [1:0] {
        RD       = 2'b00,
        RD_RSP   = 2'b01,
        WR       = 2'b10,
        WR_BCAST = 2'b11
    } t_opcode;

    typedef struct packed {
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_ring_req;

    localparam int CORE_ID_MSB = 31;
    localparam int CORE_ID_LSB = 24;

    typedef enum logic {
        IDLE,
        WAIT_RSP
    } t_init_state;

endpackage

// File: rtl/ring_req_fifo.sv
// Synchronous FIFO of ring requests; head is read combinationally from the read pointer.
module ring_req_fifo
    import lotr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  t_ring_req push_data,
    input  logic      pop,
    output t_ring_req head,
    output logic      full,
    output logic      empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    t_ring_req       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ring_req_initiator.sv
// Ring endpoint that queues core RD/WR requests, injects them into free ring slots and consumes its read response.
// Optional read-response timeout enabled by defining LOTR_RING_TIMEOUT_EN.
module ring_req_initiator
    import lotr_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic [7:0]  CoreID,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  ReqOpcode,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqData,
    output logic        RspValid,
    output logic [31:0] RspData,
    output logic        RspError,
    input  logic        RingInputValidQ500H,
    input  logic [1:0]  RingInputOpcodeQ500H,
    input  logic [31:0] RingInputAddressQ500H,
    input  logic [31:0] RingInputDataQ500H,
    output logic        RingOutputValidQ502H,
    output logic [1:0]  RingOutputOpcodeQ502H,
    output logic [31:0] RingOutputAddressQ502H,
    output logic [31:0] RingOutputDataQ502H
);

    t_ring_req   req_in;
    t_ring_req   head;
    t_ring_req   inject_req;
    t_ring_req   slot_q501;
    t_ring_req   slot_q502;
    logic        valid_q501;
    logic        valid_q502;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        ready_en;
    logic        match;
    logic        free;
    logic        inject;
    logic        timeout;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    t_init_state state;
    t_init_state state_next;

    assign req_in   = '{opcode: t_opcode'(ReqOpcode), address: ReqAddress, data: ReqData};
    assign ReqReady = ready_en && !full;
    assign push     = ReqValid && ReqReady;

    ring_req_fifo #(.DEPTH(REQ_FIFO_DEPTH)) u_fifo (
        .clk       (QClk),
        .rst_n     (RstQnnnL),
        .push      (push),
        .push_data (req_in),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Keeps ReqReady low while in reset and until the first clock edge after release.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) ready_en <= 1'b0;
        else           ready_en <= 1'b1;
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            valid_q501 <= 1'b0;
            slot_q501  <= '0;
        end else begin
            valid_q501 <= RingInputValidQ500H;
            slot_q501  <= '{opcode:  t_opcode'(RingInputOpcodeQ500H),
                            address: RingInputAddressQ500H,
                            data:    RingInputDataQ500H};
        end
    end

    // A matching response frees its slot, so the next queued request may take it in the same cycle.
    assign match  = valid_q501 && (slot_q501.opcode == RD_RSP) &&
                    (slot_q501.address[CORE_ID_MSB:CORE_ID_LSB] == CoreID) && (state == WAIT_RSP);
    assign free   = !valid_q501 || match;
    assign inject = !empty && free && ((state == IDLE) || match);
    assign pop    = inject;

    always_comb begin
        inject_req = head;
        if (head.opcode == RD) inject_req.data = {24'h0, CoreID};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (inject && head.opcode == RD) state_next = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (inject)                state_next = (head.opcode == RD) ? WAIT_RSP : IDLE;
                else if (match || timeout) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) state <= IDLE;
        else           state <= state_next;
    end

`ifdef LOTR_RING_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_count;

    // Counts only while continuously waiting on the same read; any exit or re-entry restarts at zero.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL)
            to_count <= '0;
        else if (state == WAIT_RSP && state_next == WAIT_RSP && !match)
            to_count <= to_count + 1'b1;
        else
            to_count <= '0;
    end

    assign timeout = (state == WAIT_RSP) && !match && (to_count == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            valid_q502 <= 1'b0;
            slot_q502  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
        end else begin
            if (inject) begin
                valid_q502 <= 1'b1;
                slot_q502  <= inject_req;
            end else if (match) begin
                valid_q502 <= 1'b0;
                slot_q502  <= '0;
            end else begin
                valid_q502 <= valid_q501;
                slot_q502  <= slot_q501;
            end
            rsp_valid <= match || timeout;
            rsp_data  <= match ? slot_q501.data : 32'h0;
            rsp_error <= timeout;
        end
    end

    assign RingOutputValidQ502H   = valid_q502;
    assign RingOutputOpcodeQ502H  = slot_q502.opcode;
    assign RingOutputAddressQ502H = slot_q502.address;
    assign RingOutputDataQ502H    = slot_q502.data;
    assign RspValid               = rsp_valid;
    assign RspData                = rsp_data;
    assign RspError               = rsp_error;

endmodule

// File: tb/tb_ring_req_initiator.sv
// Self-checking bench for ring_req_initiator: directed vector table plus multi-cycle sequences.
// The timeout sequence runs only when LOTR_RING_TIMEOUT_EN is defined.
module tb_ring_req_initiator;

    logic        QClk;
    logic        RstQnnnL;
    logic [7:0]  CoreID;
    logic        ReqValid;
    logic        ReqReady;
    logic [1:0]  ReqOpcode;
    logic [31:0] ReqAddress;
    logic [31:0] ReqData;
    logic        RspValid;
    logic [31:0] RspData;
    logic        RspError;
    logic        RingInputValidQ500H;
    logic [1:0]  RingInputOpcodeQ500H;
    logic [31:0] RingInputAddressQ500H;
    logic [31:0] RingInputDataQ500H;
    logic        RingOutputValidQ502H;
    logic [1:0]  RingOutputOpcodeQ502H;
    logic [31:0] RingOutputAddressQ502H;
    logic [31:0] RingOutputDataQ502H;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_RSP = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    ring_req_initiator #(.REQ_FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .QClk                   (QClk),
        .RstQnnnL               (RstQnnnL),
        .CoreID                 (CoreID),
        .ReqValid               (ReqValid),
        .ReqReady               (ReqReady),
        .ReqOpcode              (ReqOpcode),
        .ReqAddress             (ReqAddress),
        .ReqData                (ReqData),
        .RspValid               (RspValid),
        .RspData                (RspData),
        .RspError               (RspError),
        .RingInputValidQ500H    (RingInputValidQ500H),
        .RingInputOpcodeQ500H   (RingInputOpcodeQ500H),
        .RingInputAddressQ500H  (RingInputAddressQ500H),
        .RingInputDataQ500H     (RingInputDataQ500H),
        .RingOutputValidQ502H   (RingOutputValidQ502H),
        .RingOutputOpcodeQ502H  (RingOutputOpcodeQ502H),
        .RingOutputAddressQ502H (RingOutputAddressQ502H),
        .RingOutputDataQ502H    (RingOutputDataQ502H)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    typedef struct {
        logic        ring_v;
        logic [1:0]  ring_op;
        logic [31:0] ring_a;
        logic [31:0] ring_d;
        logic        req_v;
        logic [1:0]  req_op;
        logic [31:0] req_a;
        logic [31:0] req_d;
        logic        exp_v;
        logic [1:0]  exp_op;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        logic        exp_rsp_v;
        logic [31:0] exp_rsp_d;
        logic        exp_ready;
    } vec_t;

    localparam int NUM_VECS = 18;

    vec_t vecs [NUM_VECS];
    int   vectors;
    int   miscompares;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge QClk);
        #1;
    endtask

    task automatic set_ring(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        RingInputValidQ500H   = v;
        RingInputOpcodeQ500H  = op;
        RingInputAddressQ500H = a;
        RingInputDataQ500H    = d;
    endtask

    task automatic set_req(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        ReqValid   = v;
        ReqOpcode  = op;
        ReqAddress = a;
        ReqData    = d;
    endtask

    task automatic check_ring(input string tag, input logic v, input logic [1:0] op,
                              input logic [31:0] a, input logic [31:0] d);
        check_output({tag, ".out_valid"}, 64'(RingOutputValidQ502H), 64'(v));
        check_output({tag, ".out_opcode"}, 64'(RingOutputOpcodeQ502H), 64'(op));
        check_output({tag, ".out_addr"}, 64'(RingOutputAddressQ502H), 64'(a));
        check_output({tag, ".out_data"}, 64'(RingOutputDataQ502H), 64'(d));
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [31:0] d, input logic err);
        check_output({tag, ".rsp_valid"}, 64'(RspValid), 64'(v));
        check_output({tag, ".rsp_data"}, 64'(RspData), 64'(d));
        check_output({tag, ".rsp_error"}, 64'(RspError), 64'(err));
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        set_ring(v.ring_v, v.ring_op, v.ring_a, v.ring_d);
        set_req(v.req_v, v.req_op, v.req_a, v.req_d);
        tick();
        check_ring(tag, v.exp_v, v.exp_op, v.exp_a, v.exp_d);
        check_rsp(tag, v.exp_rsp_v, v.exp_rsp_d, 1'b0);
        check_output({tag, ".ready"}, 64'(ReqReady), 64'(v.exp_ready));
    endtask

    initial begin
        int acc;
        logic fire;
        logic found;
        int found_at;

        vectors     = 0;
        miscompares = 0;
        CoreID      = 8'h01;
        RstQnnnL    = 1'b0;
        set_ring(1'b0, OP_RD, 32'h0, 32'h0);
        set_req(1'b0, OP_RD, 32'h0, 32'h0);

        // ring in (v,op,a,d) | request (v,op,a,d) | expected ring out (v,op,a,d) | rsp (v,d) | ready
        vecs[0]  = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[1]  = '{1, OP_WR,  32'h0300_0010, 32'hAA,  0, OP_RD, 32'h0, 32'h0,                    0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[2]  = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    1, OP_WR,  32'h0300_0010, 32'hAA,           0, 32'h0, 1};
        vecs[3]  = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[4]  = '{0, OP_RD,  32'h0, 32'h0,           1, OP_WR, 32'h0200_0004, 32'h1234,         0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[5]  = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    1, OP_WR,  32'h0200_0004, 32'h1234,         0, 32'h0, 1};
        vecs[6]  = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[7]  = '{0, OP_RD,  32'h0, 32'h0,           1, OP_RD, 32'h0200_0008, 32'hFFFF_FFFF,    0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[8]  = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    1, OP_RD,  32'h0200_0008, 32'h0000_0001,    0, 32'h0, 1};
        vecs[9]  = '{1, OP_RSP, 32'h0100_0008, 32'hDEAD_BEEF, 0, OP_RD, 32'h0, 32'h0,              0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[10] = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    0, OP_RD,  32'h0, 32'h0,                    1, 32'hDEAD_BEEF, 1};
        vecs[11] = '{1, OP_RSP, 32'h0100_0008, 32'h55,  0, OP_RD, 32'h0, 32'h0,                    0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[12] = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    1, OP_RSP, 32'h0100_0008, 32'h55,           0, 32'h0, 1};
        vecs[13] = '{0, OP_RD,  32'h0, 32'h0,           1, OP_RD, 32'h0200_000C, 32'h0,            0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[14] = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    1, OP_RD,  32'h0200_000C, 32'h0000_0001,    0, 32'h0, 1};
        vecs[15] = '{1, OP_RSP, 32'h0100_000C, 32'hCAFE, 1, OP_WR, 32'h0300_0020, 32'hABCD,        0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};
        vecs[16] = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    1, OP_WR,  32'h0300_0020, 32'hABCD,         1, 32'hCAFE, 1};
        vecs[17] = '{0, OP_RD,  32'h0, 32'h0,           0, OP_RD, 32'h0, 32'h0,                    0, OP_RD,  32'h0, 32'h0,                    0, 32'h0, 1};

        // Reset held: everything quiet and the core port not ready.
        tick();
        tick();
        check_ring("reset", 1'b0, OP_RD, 32'h0, 32'h0);
        check_rsp("reset", 1'b0, 32'h0, 1'b0);
        check_output("reset.ready", 64'(ReqReady), 64'(0));
        RstQnnnL = 1'b1;
        tick();
        check_output("post_reset.ready", 64'(ReqReady), 64'(1));
        check_ring("post_reset", 1'b0, OP_RD, 32'h0, 32'h0);

        for (int i = 0; i < NUM_VECS; i++) apply_stimulus(vecs[i], i);

        // Busy ring for 12 cycles while the core tries to push 5 writes.
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            set_ring(1'b1, OP_WR, 32'h0300_0100 + 32'(k), 32'(k));
            set_req(1'b1, OP_WR, 32'h0200_0040 + 32'(4 * acc), 32'h100 + 32'(acc));
            fire = ReqReady;
            tick();
            if (fire) acc++;
            check_output($sformatf("busy%0d.ready", k), 64'(ReqReady), 64'(acc < 4));
            if (k == 0) check_ring("busy0", 1'b0, OP_RD, 32'h0, 32'h0);
            else        check_ring($sformatf("busy%0d", k), 1'b1, OP_WR, 32'h0300_0100 + 32'(k - 1), 32'(k - 1));
        end
        check_output("busy.accepted", 64'(acc), 64'(4));
        set_req(1'b0, OP_RD, 32'h0, 32'h0);
        set_ring(1'b0, OP_RD, 32'h0, 32'h0);
        tick();
        check_ring("drain_fwd", 1'b1, OP_WR, 32'h0300_010B, 32'd11);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_ring($sformatf("drain%0d", i), 1'b1, OP_WR, 32'h0200_0040 + 32'(4 * i), 32'h100 + 32'(i));
        end
        tick();
        check_ring("drain_done", 1'b0, OP_RD, 32'h0, 32'h0);
        check_output("drain_done.ready", 64'(ReqReady), 64'(1));

        // Reset during an outstanding read with a write still queued.
        set_req(1'b1, OP_RD, 32'h0200_0010, 32'h0);
        tick();
        set_req(1'b0, OP_RD, 32'h0, 32'h0);
        tick();
        check_ring("mid_rd", 1'b1, OP_RD, 32'h0200_0010, 32'h0000_0001);
        set_req(1'b1, OP_WR, 32'h0300_0030, 32'h5);
        tick();
        set_req(1'b0, OP_RD, 32'h0, 32'h0);
        RstQnnnL = 1'b0;
        #2;
        check_ring("mid_reset", 1'b0, OP_RD, 32'h0, 32'h0);
        check_output("mid_reset.ready", 64'(ReqReady), 64'(0));
        tick();
        RstQnnnL = 1'b1;
        tick();
        check_output("mid_release.ready", 64'(ReqReady), 64'(1));
        tick();
        tick();
        check_ring("mid_dropped", 1'b0, OP_RD, 32'h0, 32'h0);
        set_ring(1'b1, OP_RSP, 32'h0100_0010, 32'h99);
        tick();
        set_ring(1'b0, OP_RD, 32'h0, 32'h0);
        tick();
        check_ring("mid_stale_rsp", 1'b1, OP_RSP, 32'h0100_0010, 32'h99);
        check_rsp("mid_stale_rsp", 1'b0, 32'h0, 1'b0);

`ifdef LOTR_RING_TIMEOUT_EN
        // Unanswered read times out after 16 cycles in WAIT_RSP.
        set_req(1'b1, OP_RD, 32'h0200_0008, 32'h0);
        tick();
        set_req(1'b0, OP_RD, 32'h0, 32'h0);
        tick();
        check_ring("to_rd", 1'b1, OP_RD, 32'h0200_0008, 32'h0000_0001);
        found    = 1'b0;
        found_at = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            tick();
            if (RspValid) begin
                found    = 1'b1;
                found_at = i;
                check_rsp("timeout", 1'b1, 32'h0, 1'b1);
            end
        end
        check_output("timeout.seen", 64'(found), 64'(1));
        check_output("timeout.cycle", 64'(found_at), 64'(16));
        set_ring(1'b1, OP_RSP, 32'h0100_0008, 32'h1111);
        tick();
        set_ring(1'b0, OP_RD, 32'h0, 32'h0);
        tick();
        check_ring("late_rsp", 1'b1, OP_RSP, 32'h0100_0008, 32'h1111);
        check_rsp("late_rsp", 1'b0, 32'h0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
